prbs_checker_par: RTL and testbench

- Parallel, self-synchronising PRBS checker; companion and successor to the parallel PRBS generator.
- Checks W received bits per cycle against a run-time selectable polynomial (PRBS7/15/23/31).
- Acquires lock with a search/lock FSM and counts bit errors and checked bits.
- Sits after the ADC deserialiser in the BERT path; optionally detects an inverted stream.

---
 rtl/prbs_pkg.sv | 36 +++
 rtl/prbs_checker_par_predict.sv | 46 ++++
 rtl/prbs_checker_par.sv | 246 ++++++++++++++++++++++++
 tb/tb_prbs_checker_par.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// PRBS definitions shared by the parallel generator and checker.
// Contents: polynomial select encoding, tap positions, checker FSM states
// and a popcount helper. The tap tables must match the generator's.
package prbs_pkg;

    // Longest supported polynomial; sets the depth of the receive history.
    localparam int HIST_LEN = 31;

    typedef enum logic [1:0] {
        POLY_PRBS7  = 2'd0,   // x^7  + x^6  + 1
        POLY_PRBS15 = 2'd1,   // x^15 + x^14 + 1
        POLY_PRBS23 = 2'd2,   // x^23 + x^18 + 1
        POLY_PRBS31 = 2'd3    // x^31 + x^28 + 1
    } poly_e;

    // b[n] = b[n-TAP_A] ^ b[n-TAP_B], indexed by poly_sel.
    localparam int TAP_A [4] = '{7, 15, 23, 31};
    localparam int TAP_B [4] = '{6, 14, 18, 28};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Number of set bits in a word of up to 64 bits.
    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs_checker_par_predict.sv
// Combinational per-bit PRBS prediction and mismatch for one received word.
// Ports: hist (previous 31 received bits, [0] newest), in_data (bit 0 earliest),
//        poly_sel (polynomial select), mis (received XOR predicted, per bit).
module prbs_par_predict
    import prbs_pkg::*;
#(
    parameter int OutBits = 16
) (
    input  logic [HIST_LEN-1:0] hist,
    input  logic [OutBits-1:0]  in_data,
    input  logic [1:0]          poly_sel,
    output logic [OutBits-1:0]  mis
);

    // Each bit j sits at stream position n; a tap t lands either in the same
    // word (in_data[j-t]) or, if it reaches before the word, in the history
    // (hist[t-j-1], since hist[0] is the bit just before in_data[0]).
    // All four polynomials are built with constant indices and then muxed.
    for (genvar j = 0; j < OutBits; j++) begin : g_bit
        logic [3:0] pred;

        for (genvar k = 0; k < 4; k++) begin : g_poly
            localparam int TA = TAP_A[k];
            localparam int TB = TAP_B[k];
            logic bit_a;
            logic bit_b;

            if (j >= TA) begin : g_a_word
                assign bit_a = in_data[j-TA];
            end else begin : g_a_hist
                assign bit_a = hist[TA-j-1];
            end

            if (j >= TB) begin : g_b_word
                assign bit_b = in_data[j-TB];
            end else begin : g_b_hist
                assign bit_b = hist[TB-j-1];
            end

            assign pred[k] = bit_a ^ bit_b;
        end

        assign mis[j] = in_data[j] ^ pred[poly_sel];
    end

endmodule

// File: rtl/prbs_checker_par.sv
// Parallel self-synchronising PRBS checker (PRBS7/15/23/31), OutBits bits per word.
// Ports: clk, reset (async, high), en, poly_sel, in_valid/in_data, clr;
//        locked, inv_detected, err_vec, err_cnt, bit_cnt. One register stage of latency.
// Optional inverted-stream lock is built when PRBS_CHECK_INV_EN is defined.
module prbs_checker_par
    import prbs_pkg::*;
#(
    parameter int OutBits   = 16,
    parameter int CntWidth  = 48,
    parameter int LockWords = 8,
    parameter int LossWords = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          poly_sel,
    input  logic                in_valid,
    input  logic [OutBits-1:0]  in_data,
    input  logic                clr,
    output logic                locked,
    output logic                inv_detected,
    output logic [OutBits-1:0]  err_vec,
    output logic [CntWidth-1:0] err_cnt,
    output logic [CntWidth-1:0] bit_cnt
);

    localparam int SrchW = $clog2(LockWords + 1);
    localparam int LossW = $clog2(LossWords + 1);
    localparam logic [SrchW-1:0] SRCH_LAST = SrchW'(LockWords - 1);
    localparam logic [LossW-1:0] LOSS_LAST = LossW'(LossWords - 1);
    localparam logic [6:0] WORD_BITS = 7'(OutBits);
    localparam logic [6:0] HALF_BITS = 7'((OutBits + 1) / 2);

    state_e              state;
    logic [1:0]          poly_q;
    logic [HIST_LEN-1:0] hist;
    logic [HIST_LEN-1:0] hist_nxt;
    logic [OutBits-1:0]  mis_raw;
    logic [OutBits-1:0]  mis_eff;
    logic [63:0]         mis_ext;
    logic [6:0]          pop_raw;
    logic [6:0]          pop_eff;
    logic [SrchW-1:0]    srch_cnt;
    logic [LossW-1:0]    loss_cnt;
    logic                poly_chg;
    logic                hist_live;
    logic                word_clean;
    logic                word_bad;
    logic                count_en;

    // Saturating add: any carry out clamps the result to all-ones.
    function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                    input logic [6:0]          inc);
        logic [CntWidth:0] s;
        s = {1'b0, a} + {{(CntWidth-6){1'b0}}, inc};
        return s[CntWidth] ? {CntWidth{1'b1}} : s[CntWidth-1:0];
    endfunction

    prbs_par_predict #(
        .OutBits (OutBits)
    ) u_predict (
        .hist     (hist),
        .in_data  (in_data),
        .poly_sel (poly_sel),
        .mis      (mis_raw)
    );

    // History after shifting in the whole word: the latest bit (MSB) becomes hist[0].
    for (genvar k = 0; k < HIST_LEN; k++) begin : g_hist
        if (k < OutBits) begin : g_from_word
            assign hist_nxt[k] = in_data[OutBits-1-k];
        end else begin : g_from_hist
            assign hist_nxt[k] = hist[k-OutBits];
        end
    end

    always_comb begin
        mis_ext = '0;
        mis_ext[OutBits-1:0] = mis_raw;
    end

    assign pop_raw = popcount(mis_ext);

`ifdef PRBS_CHECK_INV_EN
    logic             inv_q;
    logic [SrchW-1:0] inv_cnt;
    logic             word_inv;

    // Locked onto an inverted stream: every bit mismatches, so flip before use.
    assign mis_eff      = inv_q ? ~mis_raw : mis_raw;
    assign pop_eff      = inv_q ? (WORD_BITS - pop_raw) : pop_raw;
    assign inv_detected = inv_q;
`else
    assign mis_eff      = mis_raw;
    assign pop_eff      = pop_raw;
    assign inv_detected = 1'b0;
`endif

    // A zero history would make an all-zero input look perfect; never count it.
    assign hist_live  = |hist_nxt;
    assign word_clean = (pop_raw == 7'd0) && hist_live;
    assign word_bad   = (pop_eff >= HALF_BITS);
`ifdef PRBS_CHECK_INV_EN
    assign word_inv   = (pop_raw == WORD_BITS) && hist_live;
`endif

    // poly_q trails poly_sel by one cycle, so a change is seen for exactly one cycle.
    assign poly_chg = (poly_sel != poly_q) && (state != IDLE);
    assign count_en = en && in_valid && !poly_chg && (state == LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
        end else if (in_valid) begin
            hist <= hist_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            poly_q   <= '0;
            locked   <= 1'b0;
            err_vec  <= '0;
            srch_cnt <= '0;
            loss_cnt <= '0;
`ifdef PRBS_CHECK_INV_EN
            inv_q    <= 1'b0;
            inv_cnt  <= '0;
`endif
        end else begin
            poly_q <= poly_sel;
            if (!en) begin
                state    <= IDLE;
                locked   <= 1'b0;
                err_vec  <= '0;
                srch_cnt <= '0;
                loss_cnt <= '0;
`ifdef PRBS_CHECK_INV_EN
                inv_q    <= 1'b0;
                inv_cnt  <= '0;
`endif
            end else if (poly_chg) begin
                // New polynomial: restart acquisition but keep the bit history.
                state    <= SEARCH;
                locked   <= 1'b0;
                srch_cnt <= '0;
                loss_cnt <= '0;
                if (in_valid) begin
                    err_vec <= mis_raw;
                end
`ifdef PRBS_CHECK_INV_EN
                inv_q    <= 1'b0;
                inv_cnt  <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        state    <= SEARCH;
                        err_vec  <= '0;
                        srch_cnt <= '0;
                        loss_cnt <= '0;
`ifdef PRBS_CHECK_INV_EN
                        inv_cnt  <= '0;
`endif
                    end

                    SEARCH: begin
                        if (in_valid) begin
                            err_vec <= mis_raw;
                            if (word_clean) begin
                                if (srch_cnt == SRCH_LAST) begin
                                    state    <= LOCKED;
                                    locked   <= 1'b1;
                                    srch_cnt <= '0;
                                    loss_cnt <= '0;
                                end else begin
                                    srch_cnt <= srch_cnt + 1'b1;
                                end
                            end else begin
                                srch_cnt <= '0;
                            end
`ifdef PRBS_CHECK_INV_EN
                            if (word_inv) begin
                                if (inv_cnt == SRCH_LAST) begin
                                    state    <= LOCKED;
                                    locked   <= 1'b1;
                                    inv_q    <= 1'b1;
                                    inv_cnt  <= '0;
                                    loss_cnt <= '0;
                                end else begin
                                    inv_cnt <= inv_cnt + 1'b1;
                                end
                            end else begin
                                inv_cnt <= '0;
                            end
`endif
                        end
                    end

                    LOCKED: begin
                        if (in_valid) begin
                            err_vec <= mis_eff;
                            if (word_bad) begin
                                if (loss_cnt == LOSS_LAST) begin
                                    state    <= SEARCH;
                                    locked   <= 1'b0;
                                    loss_cnt <= '0;
                                    srch_cnt <= '0;
`ifdef PRBS_CHECK_INV_EN
                                    inv_q    <= 1'b0;
                                    inv_cnt  <= '0;
`endif
                                end else begin
                                    loss_cnt <= loss_cnt + 1'b1;
                                end
                            end else begin
                                loss_cnt <= '0;
                            end
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // clr wins over a coincident increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            err_cnt <= '0;
            bit_cnt <= '0;
        end else if (count_en) begin
            err_cnt <= sat_add(err_cnt, pop_eff);
            bit_cnt <= sat_add(bit_cnt, WORD_BITS);
        end
    end

endmodule

// File: tb/tb_prbs_checker_par.sv
// Testbench for prbs_checker_par: a 48-bit-counter instance and an 8-bit-counter
// instance share all inputs; a serial LFSR in the bench produces the streams.
module tb_prbs_checker_par;

    logic        clk;
    logic        reset;
    logic        en;
    logic [1:0]  poly_sel;
    logic        in_valid;
    logic [15:0] in_data;
    logic        clr;

    logic        locked,  locked8;
    logic        inv_det, inv_det8;
    logic [15:0] err_vec, err_vec8;
    logic [47:0] err_cnt, bit_cnt;
    logic [7:0]  err_cnt8, bit_cnt8;

    int checks = 0;
    int passes = 0;

    // Bench stream generator: true sequence history, [0] newest.
    logic [30:0] g_hist;
    int          g_ta, g_tb;
    logic        g_inv;

    prbs_checker_par #(.OutBits(16), .CntWidth(48)) u_dut (
        .clk(clk), .reset(reset), .en(en), .poly_sel(poly_sel),
        .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .locked(locked), .inv_detected(inv_det), .err_vec(err_vec),
        .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    prbs_checker_par #(.OutBits(16), .CntWidth(8)) u_dut8 (
        .clk(clk), .reset(reset), .en(en), .poly_sel(poly_sel),
        .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .locked(locked8), .inv_detected(inv_det8), .err_vec(err_vec8),
        .err_cnt(err_cnt8), .bit_cnt(bit_cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic gen_word(output logic [15:0] w);
        logic b;
        for (int j = 0; j < 16; j++) begin
            b      = g_hist[g_ta-1] ^ g_hist[g_tb-1];
            w[j]   = b ^ g_inv;
            g_hist = {g_hist[29:0], b};
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic send_word(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Prime 32 bits of history while disabled, then enable and clear counters.
    task automatic start_stream(input int poly, input logic inv);
        logic [15:0] w;
        en       = 1'b0;
        poly_sel = 2'(poly);
        case (poly)
            0:       begin g_ta = 7;  g_tb = 6;  end
            1:       begin g_ta = 15; g_tb = 14; end
            2:       begin g_ta = 23; g_tb = 18; end
            default: begin g_ta = 31; g_tb = 28; end
        endcase
        g_hist = 31'h1234567;
        g_inv  = inv;
        for (int i = 0; i < 2; i++) begin
            gen_word(w);
            send_word(w);
        end
        en  = 1'b1;
        clr = 1'b1;
        idle_cycle();
        clr = 1'b0;
    endtask

    task automatic lock_words(input string name);
        logic [15:0] w;
        for (int i = 1; i <= 8; i++) begin
            gen_word(w);
            send_word(w);
            checks++;
            if (locked !== (i == 8)) $display("FAIL %s_word%0d locked=%0b exp=%0b", name, i, locked, (i == 8));
            else passes++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({locked, inv_det, err_vec, err_cnt, bit_cnt} !== '0)
            $display("FAIL reset_state locked=%0b inv=%0b err_vec=%h err=%0d bits=%0d exp all 0",
                     locked, inv_det, err_vec, err_cnt, bit_cnt);
        else passes++;
        checks++;
        if ({locked8, inv_det8, err_vec8, err_cnt8, bit_cnt8} !== '0)
            $display("FAIL reset_state8 locked=%0b err=%0d bits=%0d exp all 0", locked8, err_cnt8, bit_cnt8);
        else passes++;
    endtask

    task automatic test_prbs7_lock();
        logic [15:0] w;
        start_stream(0, 1'b0);
        checks++;
        if (err_vec !== 16'h0 || locked !== 1'b0) $display("FAIL idle_errvec err_vec=%h locked=%0b exp 0/0", err_vec, locked);
        else passes++;
        lock_words("prbs7_lock");
        for (int i = 0; i < 3; i++) begin
            gen_word(w);
            send_word(w);
        end
        checks++;
        if (bit_cnt !== 48'd48 || err_cnt !== 48'd0 || err_vec !== 16'h0)
            $display("FAIL prbs7_count bits=%0d err=%0d err_vec=%h exp 48/0/0", bit_cnt, err_cnt, err_vec);
        else passes++;
    endtask

    // Flip at word offset 2: mismatches at +0, +28, +31 -> word i bit 2, i+1 bit 14, i+2 bit 1.
    task automatic test_single_error();
        logic [15:0] w;
        logic [15:0] exp_vec [5] = '{16'h0000, 16'h0004, 16'h4000, 16'h0002, 16'h0000};
        start_stream(3, 1'b0);
        lock_words("prbs31_lock");
        for (int i = 0; i < 5; i++) begin
            gen_word(w);
            if (i == 1) w[2] = ~w[2];
            send_word(w);
            checks++;
            if (err_vec !== exp_vec[i]) $display("FAIL single_err_vec%0d err_vec=%h exp=%h", i, err_vec, exp_vec[i]);
            else passes++;
        end
        checks++;
        if (err_cnt !== 48'd3 || bit_cnt !== 48'd80 || locked !== 1'b1)
            $display("FAIL single_err_cnt err=%0d bits=%0d locked=%0b exp 3/80/1", err_cnt, bit_cnt, locked);
        else passes++;
    endtask

    task automatic test_poly_change();
        poly_sel = 2'd0;
        idle_cycle();
        checks++;
        if (locked !== 1'b0 || err_cnt !== 48'd3)
            $display("FAIL poly_change locked=%0b err=%0d exp 0/3", locked, err_cnt);
        else passes++;
    endtask

    task automatic test_all_zero();
        int seen = 0;
        en       = 1'b0;
        poly_sel = 2'd0;
        send_word(16'h0);
        send_word(16'h0);
        en  = 1'b1;
        clr = 1'b1;
        idle_cycle();
        clr = 1'b0;
        for (int i = 0; i < 100; i++) begin
            send_word(16'h0);
            if (locked) seen = 1;
        end
        checks++;
        if (seen !== 0) $display("FAIL zero_nolock seen_lock=%0d exp 0", seen);
        else passes++;
        checks++;
        if (err_cnt !== 48'd0 || bit_cnt !== 48'd0 || err_vec !== 16'h0)
            $display("FAIL zero_counts err=%0d bits=%0d err_vec=%h exp 0/0/0", err_cnt, bit_cnt, err_vec);
        else passes++;
    endtask

    // Complemented words: first 15 mismatches (bit 14 cancels), then 16 each -> 63.
    // On resuming, the first true word mismatches at bit 14 only, so relock takes 9 words.
    task automatic test_loss_relock();
        logic [15:0] w;
        start_stream(1, 1'b0);
        lock_words("prbs15_lock");
        for (int i = 0; i < 2; i++) begin
            gen_word(w);
            send_word(w);
        end
        g_inv = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            gen_word(w);
            send_word(w);
            checks++;
            if (locked !== (i < 4)) $display("FAIL loss_word%0d locked=%0b exp=%0b", i, locked, (i < 4));
            else passes++;
            if (i == 1) begin
                checks++;
                if (err_vec !== 16'hBFFF) $display("FAIL loss_errvec err_vec=%h exp=bfff", err_vec);
                else passes++;
            end
        end
        g_inv = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            gen_word(w);
            send_word(w);
            if (i == 1) begin
                checks++;
                if (err_vec !== 16'h4000) $display("FAIL resume_errvec err_vec=%h exp=4000", err_vec);
                else passes++;
            end
            if (i >= 8) begin
                checks++;
                if (locked !== (i == 9)) $display("FAIL relock_word%0d locked=%0b exp=%0b", i, locked, (i == 9));
                else passes++;
            end
        end
        checks++;
        if (err_cnt !== 48'd63 || bit_cnt !== 48'd96)
            $display("FAIL loss_hold err=%0d bits=%0d exp 63/96", err_cnt, bit_cnt);
        else passes++;
        clr = 1'b1;
        idle_cycle();
        clr = 1'b0;
        checks++;
        if (err_cnt !== 48'd0 || bit_cnt !== 48'd0) $display("FAIL loss_clr err=%0d bits=%0d exp 0/0", err_cnt, bit_cnt);
        else passes++;
    endtask

    // PRBS7 with bit 0 flipped per word: mismatches at bits 0, 6, 7 -> 3 errors/word.
    task automatic test_saturation();
        logic [15:0] w;
        start_stream(0, 1'b0);
        lock_words("sat_lock");
        for (int i = 1; i <= 90; i++) begin
            gen_word(w);
            w[0] = ~w[0];
            send_word(w);
            if (i == 1) begin
                checks++;
                if (err_vec8 !== 16'h00C1) $display("FAIL sat_errvec err_vec=%h exp=00c1", err_vec8);
                else passes++;
            end
            if (i == 84) begin
                checks++;
                if (err_cnt8 !== 8'd252) $display("FAIL sat_pre err=%0d exp=252", err_cnt8);
                else passes++;
            end
        end
        checks++;
        if (err_cnt8 !== 8'hFF || bit_cnt8 !== 8'hFF || locked8 !== 1'b1)
            $display("FAIL sat_clamp8 err=%0d bits=%0d locked=%0b exp 255/255/1", err_cnt8, bit_cnt8, locked8);
        else passes++;
        checks++;
        if (err_cnt !== 48'd270 || bit_cnt !== 48'd1440)
            $display("FAIL sat_wide err=%0d bits=%0d exp 270/1440", err_cnt, bit_cnt);
        else passes++;
        gen_word(w);
        w[0] = ~w[0];
        clr  = 1'b1;
        send_word(w);
        clr  = 1'b0;
        checks++;
        if (err_cnt8 !== 8'd0 || bit_cnt8 !== 8'd0 || err_cnt !== 48'd0 || bit_cnt !== 48'd0)
            $display("FAIL clr_wins err8=%0d bits8=%0d err=%0d bits=%0d exp all 0", err_cnt8, bit_cnt8, err_cnt, bit_cnt);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] w;
        gen_word(w);
        w[0] = ~w[0];
        send_word(w);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (locked !== 1'b0 || err_cnt !== 48'd0 || bit_cnt !== 48'd0 || err_vec !== 16'h0)
            $display("FAIL reset_mid locked=%0b err=%0d bits=%0d err_vec=%h exp all 0", locked, err_cnt, bit_cnt, err_vec);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_inverted();
        logic [15:0] w;
        int seen = 0;
        start_stream(2, 1'b1);
`ifdef PRBS_CHECK_INV_EN
        lock_words("inv_lock");
        checks++;
        if (inv_det !== 1'b1) $display("FAIL inv_detect inv=%0b exp=1", inv_det);
        else passes++;
        for (int i = 0; i < 2; i++) begin
            gen_word(w);
            send_word(w);
        end
        checks++;
        if (err_cnt !== 48'd0 || bit_cnt !== 48'd32 || err_vec !== 16'h0)
            $display("FAIL inv_count err=%0d bits=%0d err_vec=%h exp 0/32/0", err_cnt, bit_cnt, err_vec);
        else passes++;
`else
        for (int i = 0; i < 16; i++) begin
            gen_word(w);
            send_word(w);
            if (locked) seen = 1;
        end
        checks++;
        if (seen !== 0 || inv_det !== 1'b0) $display("FAIL inv_nolock seen_lock=%0d inv=%0b exp 0/0", seen, inv_det);
        else passes++;
        checks++;
        if (err_vec !== 16'hFFFF) $display("FAIL inv_errvec err_vec=%h exp=ffff", err_vec);
        else passes++;
`endif
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        poly_sel = 2'd0;
        in_valid = 1'b0;
        in_data  = 16'h0;
        clr      = 1'b0;
        g_hist   = 31'h1234567;
        g_ta     = 7;
        g_tb     = 6;
        g_inv    = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        idle_cycle();
        test_prbs7_lock();
        test_single_error();
        test_poly_change();
        test_all_zero();
        test_loss_relock();
        test_saturation();
        test_reset_mid();
        test_inverted();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
